// File: rtl/adpll_lock_detector.sv
// ADPLL lock detector: qualifies phase-error samples, declares lock/unlock with hysteresis, sticky acquisition timeout; DCO range tracking under ADPLL_LOCK_DCO_RANGE_EN.
// Latency: every output is registered and reflects a sample on the clock edge after error_valid_i.
// Backpressure: none; a sample is consumed in the cycle its strobe is high and cannot be stalled.
module adpll_lock_detector #(
  parameter int ERROR_WIDTH    = 8,
  parameter int DCO_CC_WIDTH   = 5,
  parameter int LOCK_TOL       = 2,
  parameter int UNLOCK_TOL     = 4,
  parameter int LOCK_COUNT     = 16,
  parameter int UNLOCK_COUNT   = 4,
  parameter int CNT_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int TIMER_WIDTH    = 20
) (
  input  logic                           fpga_clk_i,
  input  logic                           reset_i,
  input  logic                           enable_i,
  input  logic                           error_valid_i,
  input  logic signed [ERROR_WIDTH-1:0]  error_i,
  input  logic signed [DCO_CC_WIDTH-1:0] dco_cc_i,
  output logic                           locked_o,
  output logic [1:0]                     state_o,
  output logic                           lock_lost_o,
  output logic                           acq_timeout_o,
  output logic [CNT_WIDTH-1:0]           good_cnt_o,
  output logic signed [DCO_CC_WIDTH-1:0] dco_min_o,
  output logic signed [DCO_CC_WIDTH-1:0] dco_max_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [ERROR_WIDTH-1:0] ERR_MIN     = {1'b1, {(ERROR_WIDTH-1){1'b0}}};
  localparam logic [ERROR_WIDTH-1:0] ERR_MAX     = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
  localparam logic [ERROR_WIDTH-1:0] LOCK_TOL_W  = ERROR_WIDTH'(LOCK_TOL);
  localparam logic [ERROR_WIDTH-1:0] UNLOCK_TOL_W = ERROR_WIDTH'(UNLOCK_TOL);
  localparam logic [CNT_WIDTH-1:0]   LOCK_CNT_W  = CNT_WIDTH'(LOCK_COUNT);
  localparam logic [CNT_WIDTH-1:0]   LOCK_LAST   = CNT_WIDTH'(LOCK_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0]   UNLOCK_LAST = CNT_WIDTH'(UNLOCK_COUNT - 1);
  localparam logic [TIMER_WIDTH-1:0] TIMER_LAST  = TIMER_WIDTH'(TIMEOUT_CYCLES - 1);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
  logic [TIMER_WIDTH-1:0]  timer_q, timer_d;
  logic                    acq_timeout_q, acq_timeout_d;
  logic                    locked_q, locked_d;
  logic                    lock_lost_q, lock_lost_d;
  logic [ERROR_WIDTH-1:0]  abs_err;
  logic                    good_sample;
  logic                    miss_sample;

  // The most-negative code has no positive twin, so it saturates.
  always_comb begin
    abs_err = error_i;
    if (error_i[ERROR_WIDTH-1]) begin
      if (error_i == ERR_MIN) abs_err = ERR_MAX;
      else                    abs_err = -error_i;
    end
  end

  assign good_sample = error_valid_i && (abs_err <= LOCK_TOL_W);
  assign miss_sample = error_valid_i && (abs_err >  UNLOCK_TOL_W);

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i) begin
      state_q       <= IDLE;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      timer_q       <= '0;
      acq_timeout_q <= 1'b0;
      locked_q      <= 1'b0;
      lock_lost_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      timer_q       <= timer_d;
      acq_timeout_q <= acq_timeout_d;
      locked_q      <= locked_d;
      lock_lost_q   <= lock_lost_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    good_cnt_d    = good_cnt_q;
    miss_cnt_d    = miss_cnt_q;
    timer_d       = timer_q;
    acq_timeout_d = acq_timeout_q;
    if (!enable_i) begin
      state_d       = IDLE;
      good_cnt_d    = '0;
      miss_cnt_d    = '0;
      timer_d       = '0;
      acq_timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d       = ACQUIRE;
          good_cnt_d    = '0;
          miss_cnt_d    = '0;
          timer_d       = '0;
          acq_timeout_d = 1'b0;
        end
        ACQUIRE: begin
          if (timer_q != TIMER_LAST) timer_d = timer_q + 1'b1;
          if (timer_d == TIMER_LAST) acq_timeout_d = 1'b1;
          if (good_sample) begin
            if (good_cnt_q >= LOCK_LAST) begin
              good_cnt_d = LOCK_CNT_W;
              state_d    = LOCKED;
            end else begin
              good_cnt_d = good_cnt_q + 1'b1;
            end
          end else if (error_valid_i) begin
            good_cnt_d = '0;
          end
        end
        LOCKED: begin
          if (miss_sample) begin
            if (UNLOCK_COUNT == 1) begin
              state_d       = ACQUIRE;
              good_cnt_d    = '0;
              miss_cnt_d    = '0;
              timer_d       = '0;
              acq_timeout_d = 1'b0;
            end else begin
              state_d    = HOLD;
              miss_cnt_d = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            end
          end
        end
        HOLD: begin
          if (miss_sample) begin
            if (miss_cnt_q >= UNLOCK_LAST) begin
              state_d       = ACQUIRE;
              good_cnt_d    = '0;
              miss_cnt_d    = '0;
              timer_d       = '0;
              acq_timeout_d = 1'b0;
            end else begin
              miss_cnt_d = miss_cnt_q + 1'b1;
            end
          end else if (error_valid_i) begin
            state_d    = LOCKED;
            miss_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Lock loss is any LOCKED/HOLD -> ACQUIRE move; disable goes to IDLE and never pulses.
  always_comb begin
    locked_d    = (state_d == LOCKED) || (state_d == HOLD);
    lock_lost_d = ((state_q == LOCKED) || (state_q == HOLD)) && (state_d == ACQUIRE);
  end

  assign state_o       = state_q;
  assign locked_o      = locked_q;
  assign lock_lost_o   = lock_lost_q;
  assign acq_timeout_o = acq_timeout_q;
  assign good_cnt_o    = good_cnt_q;

`ifdef ADPLL_LOCK_DCO_RANGE_EN
  logic signed [DCO_CC_WIDTH-1:0] dco_min_q, dco_max_q;

  always_ff @(posedge fpga_clk_i) begin
    if (!reset_i || (state_d == IDLE)) begin
      dco_min_q <= '0;
      dco_max_q <= '0;
    end else if ((state_q == ACQUIRE) && (state_d == LOCKED)) begin
      dco_min_q <= dco_cc_i;
      dco_max_q <= dco_cc_i;
    end else if ((state_q == LOCKED) || (state_q == HOLD)) begin
      if (dco_cc_i < dco_min_q) dco_min_q <= dco_cc_i;
      if (dco_cc_i > dco_max_q) dco_max_q <= dco_cc_i;
    end
  end

  assign dco_min_o = dco_min_q;
  assign dco_max_o = dco_max_q;
`else
  logic unused_dco;
  assign unused_dco = ^dco_cc_i;
  assign dco_min_o  = '0;
  assign dco_max_o  = '0;
`endif

endmodule

// File: tb/tb_adpll_lock_detector.sv
// Bench for adpll_lock_detector: vector table driven into the DUT, expectations queued and compared one edge later.
module tb_adpll_lock_detector;

  logic              fpga_clk_i = 1'b0;
  logic              reset_i;
  logic              enable_i;
  logic              error_valid_i;
  logic signed [7:0] error_i;
  logic signed [4:0] dco_cc_i;
  logic              locked_o;
  logic [1:0]        state_o;
  logic              lock_lost_o;
  logic              acq_timeout_o;
  logic [7:0]        good_cnt_o;
  logic signed [4:0] dco_min_o;
  logic signed [4:0] dco_max_o;

  always #5 fpga_clk_i = ~fpga_clk_i;

  adpll_lock_detector #(
    .ERROR_WIDTH(8), .DCO_CC_WIDTH(5), .LOCK_TOL(2), .UNLOCK_TOL(4),
    .LOCK_COUNT(16), .UNLOCK_COUNT(4), .CNT_WIDTH(8),
    .TIMEOUT_CYCLES(100), .TIMER_WIDTH(20)
  ) dut (
    .fpga_clk_i(fpga_clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .error_valid_i(error_valid_i), .error_i(error_i), .dco_cc_i(dco_cc_i),
    .locked_o(locked_o), .state_o(state_o), .lock_lost_o(lock_lost_o),
    .acq_timeout_o(acq_timeout_o), .good_cnt_o(good_cnt_o),
    .dco_min_o(dco_min_o), .dco_max_o(dco_max_o)
  );

  typedef struct {
    logic              rst;
    logic              en;
    logic              vld;
    logic signed [7:0] err;
    logic signed [4:0] dco;
    int                st;
    int                lk;
    int                ll;
    int                to;
    int                gc;
    int                dmin;
    int                dmax;
    string             nm;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cur_dco  = 0;
  int   cur_dmin = 0;
  int   cur_dmax = 0;

  function automatic void add(input bit rst, input bit en, input bit vld, input int err,
                              input int st, input int lk, input int ll, input int to,
                              input int gc, input string nm);
    vec_t v;
    v.rst = rst; v.en = en; v.vld = vld;
    v.err = 8'(err); v.dco = 5'(cur_dco);
    v.st = st; v.lk = lk; v.ll = ll; v.to = to; v.gc = gc;
    v.dmin = cur_dmin; v.dmax = cur_dmax; v.nm = nm;
    vecs.push_back(v);
  endfunction

  function automatic void chk(input string nm, input string fld, input int idx,
                              input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s.%s vec %0d: actual %0d required %0d", nm, fld, idx, act, exp);
    end
  endfunction

  initial begin
    vec_t e;
    int   emin, emax;
    reset_i = 1'b0; enable_i = 1'b0; error_valid_i = 1'b0; error_i = '0; dco_cc_i = '0;

    // reset dominates an active enable and strobe
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, "reset");
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, "reset");
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, "idle_to_acq");
    for (int k = 1; k <= 16; k++)
      add(1, 1, 1, 1, (k == 16) ? 2 : 1, (k == 16) ? 1 : 0, 0, 0, k, "acq_lock");
    add(1, 1, 1, 4,  2, 1, 0, 0, 16, "hyst_band");
    add(1, 1, 1, -4, 2, 1, 0, 0, 16, "hyst_band");
    add(1, 1, 1, 4,  2, 1, 0, 0, 16, "hyst_band");
    add(1, 1, 1, 5,  3, 1, 0, 0, 16, "hold_enter");
    add(1, 1, 1, 5,  3, 1, 0, 0, 16, "hold_miss2");
    add(1, 1, 1, 0,  2, 1, 0, 0, 16, "hold_recover");
    add(1, 1, 1, -6, 3, 1, 0, 0, 16, "miss1");
    add(1, 1, 1, 7,  3, 1, 0, 0, 16, "miss2");
    add(1, 1, 1, 5,  3, 1, 0, 0, 16, "miss3");
    add(1, 1, 1, -5, 1, 0, 1, 0, 0,  "lock_lost");
    cur_dco = 3;
    for (int k = 1; k <= 10; k++)
      add(1, 1, 1, -2, 1, 0, 0, 0, k, "reacq_good");
    add(1, 1, 0, 3, 1, 0, 0, 0, 10, "nonvalid_hold");
    add(1, 1, 1, 3, 1, 0, 0, 0, 0,  "bad_resets");
    for (int k = 1; k <= 16; k++) begin
      if (k == 16) begin cur_dmin = 3; cur_dmax = 3; end
      add(1, 1, 1, 0, (k == 16) ? 2 : 1, (k == 16) ? 1 : 0, 0, 0, k, "reacq_lock");
    end
    cur_dco = -2; cur_dmin = -2;
    add(1, 1, 0, 0, 2, 1, 0, 0, 16, "dco_min");
    cur_dco = 7;  cur_dmax = 7;
    add(1, 1, 0, 0, 2, 1, 0, 0, 16, "dco_max");
    cur_dco = 0;
    add(1, 1, 1, -128, 3, 1, 0, 0, 16, "neg_sat");
    cur_dmin = 0; cur_dmax = 0;
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "disable");
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, "reenable");
    add(1, 1, 1, 0, 1, 0, 0, 0, 1, "acq_good");
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, "disable_wins");
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, "to_enter");
    for (int k = 1; k <= 99; k++)
      add(1, 1, 1, 50, 1, 0, 0, (k == 99) ? 1 : 0, 0, "to_count");
    for (int k = 1; k <= 3; k++)
      add(1, 1, 1, 50, 1, 0, 0, 1, 0, "to_sticky");
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, "to_clear");
    add(1, 1, 0, 0, 1, 0, 0, 0, 0, "to_reenter");
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, "reset_again");

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge fpga_clk_i);
      reset_i       = vecs[i].rst;
      enable_i      = vecs[i].en;
      error_valid_i = vecs[i].vld;
      error_i       = vecs[i].err;
      dco_cc_i      = vecs[i].dco;
      exp_q.push_back(vecs[i]);
      @(posedge fpga_clk_i);
      #1;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard vec %0d: actual empty queue required one entry", i);
      end else begin
        e = exp_q.pop_front();
`ifdef ADPLL_LOCK_DCO_RANGE_EN
        emin = e.dmin; emax = e.dmax;
`else
        emin = 0; emax = 0;
`endif
        chk(e.nm, "state",    i, int'(state_o),         e.st);
        chk(e.nm, "locked",   i, int'(locked_o),        e.lk);
        chk(e.nm, "lost",     i, int'(lock_lost_o),     e.ll);
        chk(e.nm, "timeout",  i, int'(acq_timeout_o),   e.to);
        chk(e.nm, "good_cnt", i, int'(good_cnt_o),      e.gc);
        chk(e.nm, "dco_min",  i, int'($signed(dco_min_o)), emin);
        chk(e.nm, "dco_max",  i, int'($signed(dco_max_o)), emax);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/adpll_lock_detector.md
Name: adpll_lock_detector

Overview:
Downstream consumer of the ring ADPLL's signed phase-error word (error_o) and DCO control code (dco_cc_o). Runs in the fpga_clk_i domain, qualifies each phase-detector update against tolerance windows and declares lock or loss of lock with hysteresis. Raises a sticky acquisition timeout when lock is not reached. Status feeds the top-level LEDs and debug logic.

Parameters:
ERROR_WIDTH, 8, width of signed phase error input
DCO_CC_WIDTH, 5, width of signed DCO control code input
LOCK_TOL, 2, |error| <= LOCK_TOL counts as good sample during acquisition
UNLOCK_TOL, 4, |error| > UNLOCK_TOL counts as miss while locked; must be >= LOCK_TOL
LOCK_COUNT, 16, consecutive good samples required to declare lock (>= 1)
UNLOCK_COUNT, 4, consecutive misses required to drop lock (>= 1)
CNT_WIDTH, 8, width of good/miss counters; must hold LOCK_COUNT and UNLOCK_COUNT
TIMEOUT_CYCLES, 1000000, fpga_clk_i cycles allowed in ACQUIRE before timeout
TIMER_WIDTH, 20, acquisition timer width; must hold TIMEOUT_CYCLES

Ports:
fpga_clk_i  input  1  system clock; all logic on rising edge
reset_i  input  1  synchronous, active-low reset
enable_i  input  1  detector enable; low forces IDLE
error_valid_i  input  1  one-cycle strobe: error_i holds a new phase-detector result
error_i  input  ERROR_WIDTH  signed phase error
dco_cc_i  input  DCO_CC_WIDTH  signed DCO control code (used only with optional feature)
locked_o  output  1  high in LOCKED and HOLD
state_o  output  2  0=IDLE, 1=ACQUIRE, 2=LOCKED, 3=HOLD
lock_lost_o  output  1  one-cycle pulse on HOLD->ACQUIRE
acq_timeout_o  output  1  sticky acquisition timeout flag
good_cnt_o  output  CNT_WIDTH  current consecutive-good count
dco_min_o  output  DCO_CC_WIDTH  signed min dco_cc_i seen while locked
dco_max_o  output  DCO_CC_WIDTH  signed max dco_cc_i seen while locked

Behaviour:
- Reset (reset_i==0 at clock edge): state IDLE; all outputs, counters and timer set to 0.
- All outputs registered. The response to a sample appears on the clock edge after the cycle in which error_valid_i is high.
- abs_err = |error_i|. The most-negative input saturates to 2^(ERROR_WIDTH-1)-1. Comparisons are unsigned on abs_err.
- enable_i==0 in any state: next state IDLE, locked_o=0, counters and timer cleared, acq_timeout_o cleared, no lock_lost_o pulse.
- IDLE: enable_i==1 -> ACQUIRE, counters and timer cleared.
- ACQUIRE: timer increments every cycle and saturates at TIMEOUT_CYCLES-1. Reaching that value sets acq_timeout_o, which holds until enable_i low or reset. State stays ACQUIRE.
- ACQUIRE on valid sample: abs_err<=LOCK_TOL increments good_cnt; otherwise good_cnt=0. The increment that makes good_cnt==LOCK_COUNT moves to LOCKED and sets locked_o=1 on the same edge. good_cnt then holds at LOCK_COUNT.
- LOCKED on valid sample: abs_err>UNLOCK_TOL sets miss_cnt=1 and moves to HOLD. If UNLOCK_COUNT==1, it moves directly to ACQUIRE instead, with the lock_lost_o pulse.
- HOLD: locked_o stays 1.
  - A valid sample with abs_err<=UNLOCK_TOL moves back to LOCKED with miss_cnt=0.
  - A valid miss increments miss_cnt. When miss_cnt reaches UNLOCK_COUNT: go to ACQUIRE, locked_o=0, lock_lost_o=1 for one cycle, good_cnt=0, timer=0, acq_timeout_o=0.
- Samples with UNLOCK_TOL>=abs_err>LOCK_TOL in LOCKED are not misses (hysteresis band).
- Non-valid cycles never change counters, except for the ACQUIRE timer.
- Simultaneous enable_i fall and error_valid_i: disable wins.
- Counters never wrap; good_cnt and miss_cnt saturate at their targets.

Optional Feature:
ADPLL_LOCK_DCO_RANGE_EN
- Defined: while state is LOCKED or HOLD, dco_min_o and dco_max_o track the signed min/max of dco_cc_i, sampled every cycle. On entry to LOCKED from ACQUIRE, both load the current dco_cc_i. Values hold after lock loss until the next lock entry, IDLE or reset, which clears them to 0.
- Not defined: dco_min_o and dco_max_o are tied to 0 and no tracking registers are built.

Test Plan:
- Reset release, enable_i=1, 16 valid samples of error_i=1 -> state_o 1 then 2 one edge after the 16th sample; locked_o=1; good_cnt_o=16.
- ACQUIRE: 10 samples of error_i=-2, one of error_i=3, then 16 of error_i=0 -> good_cnt_o resets to 0 after the error_i=3 sample; lock is declared only after the 16th subsequent good sample.
- Locked, samples 4,-4,4 (within UNLOCK_TOL) -> stays LOCKED. Then 5,5,0 -> HOLD then LOCKED, miss count cleared. Then -6,7,5,-5 -> one-cycle lock_lost_o, state_o=1, locked_o=0.
- error_i=-128 with ERROR_WIDTH=8 in LOCKED -> treated as abs 127 -> miss, enters HOLD.
- TIMEOUT_CYCLES=100, error_i=50 continuously -> acq_timeout_o rises after 99 cycles in ACQUIRE and stays high; enable_i low for one cycle clears it and sets state_o=0.
- With ADPLL_LOCK_DCO_RANGE_EN: lock at dco_cc_i=3, then drive -2 and 7 -> dco_min_o=-2, dco_max_o=7. Without the macro both read 0.
